// File: rtl/seq_div_unit.sv
// seq_div_unit: iterative radix-2 restoring divider, responder side of the
// EX-stage start/ready divide handshake. Returns {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the result
// {dividend, 0} is produced straight from IDLE without iterating.
module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BY_ZERO, BUSY, DONE} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] dvd_q, dvd_n;   // dividend, shifted out MSB first
  logic [WIDTH-1:0] dvs_q, dvs_n;   // |divisor|
  logic [WIDTH-1:0] rem_q, rem_n;   // partial remainder
  logic [WIDTH-1:0] quo_q, quo_n;   // quotient, shifted in LSB first
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             qsgn_q, qsgn_n;
  logic             rsgn_q, rsgn_n;
  logic [2*WIDTH-1:0] result_n;
  logic             ready_n;

  // Operand magnitudes; only negated for a signed divide with MSB set,
  // so |MIN| naturally comes out as the unsigned value 2^(WIDTH-1).
  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign b_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  // The extra top bit of diff is the borrow: set means "restore".
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             keep;
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign diff   = {1'b0, rem_sh} - {2'b0, dvs_q};
  assign keep   = ~diff[WIDTH+1];

  // Sign-corrected final values; negation wraps to WIDTH bits.
  logic [WIDTH-1:0] quo_fin, rem_fin;
  assign quo_fin = qsgn_q ? -quo_q : quo_q;
  assign rem_fin = rsgn_q ? -rem_q : rem_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      qsgn_q   <= 1'b0;
      rsgn_q   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state_q  <= state_n;
      dvd_q    <= dvd_n;
      dvs_q    <= dvs_n;
      rem_q    <= rem_n;
      quo_q    <= quo_n;
      cnt_q    <= cnt_n;
      qsgn_q   <= qsgn_n;
      rsgn_q   <= rsgn_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

  // Next-state and datapath update; everything holds unless a state says otherwise.
  always_comb begin
    state_n  = state_q;
    dvd_n    = dvd_q;
    dvs_n    = dvs_q;
    rem_n    = rem_q;
    quo_n    = quo_q;
    cnt_n    = cnt_q;
    qsgn_n   = qsgn_q;
    rsgn_n   = rsgn_q;
    result_n = result_o;
    ready_n  = ready_o;
    case (state_q)
      IDLE: begin
        ready_n  = 1'b0;
        result_n = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = BY_ZERO;
`ifdef DIV_EARLY_OUT_EN
          end else if (a_abs < b_abs) begin
            // Quotient is zero and the raw dividend already carries the
            // correct remainder sign.
            state_n  = DONE;
            result_n = {opdata1_i, {WIDTH{1'b0}}};
            ready_n  = 1'b1;
`endif
          end else begin
            state_n = BUSY;
            dvd_n   = a_abs;
            dvs_n   = b_abs;
            rem_n   = '0;
            quo_n   = '0;
            cnt_n   = '0;
            qsgn_n  = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rsgn_n  = signed_div_i & opdata1_i[WIDTH-1];
          end
        end
      end
      BY_ZERO: begin
        state_n  = DONE;
        result_n = '0;
        ready_n  = 1'b1;
      end
      BUSY: begin
        if (annul_i || !start_i) begin
          state_n  = IDLE;
          result_n = '0;
          ready_n  = 1'b0;
        end else if (cnt_q == CW'(WIDTH)) begin
          state_n  = DONE;
          result_n = {rem_fin, quo_fin};
          ready_n  = 1'b1;
        end else begin
          rem_n = keep ? WIDTH'(diff) : rem_sh[WIDTH-1:0];
          quo_n = {quo_q[WIDTH-2:0], keep};
          dvd_n = dvd_q << 1;
          cnt_n = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!start_i) begin
          state_n  = IDLE;
          result_n = '0;
          ready_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/seq_div_unit.md
Name: seq_div_unit

Overview:
- Iterative radix-2 restoring divider; the responder side of the EX-stage start/ready divide handshake.
- EX holds start_i high and stalls the pipeline until ready_o rises, then drops start_i.
- Returns {remainder, quotient}; EX writes the remainder to HI and the quotient to LO.
- Supports signed (DIV) and unsigned (DIVU) division, divide-by-zero, and annul.

Parameters:
WIDTH, 32, operand width; result_o is 2*WIDTH; iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous reset, active-high
signed_div_i  input  1  1 = signed (two's complement) divide, 0 = unsigned
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
start_i  input  1  request; held high by the initiator until it sees ready_o
annul_i  input  1  abort the division in progress
result_o  output  2*WIDTH  [2W-1:W] remainder, [W-1:0] quotient; registered
ready_o  output  1  result valid; registered

Behaviour:
- Reset: state IDLE, result_o=0, ready_o=0, internal counter and datapath cleared. Reset is synchronous and active-high. Reset mid-operation aborts at the next edge with no ready_o pulse.
- States: IDLE, BY_ZERO, BUSY, DONE.
- IDLE, start_i=1 and annul_i=0:
  - opdata2_i==0 -> BY_ZERO.
  - Otherwise latch |dividend|, |divisor|, quotient sign (signed and signs differ), remainder sign (signed and dividend negative). Clear counter; go to BUSY.
  - Absolute value is taken only when signed_div_i=1 and the MSB is set. Otherwise the operand is used raw.
- IDLE, start_i=0: stay; ready_o=0, result_o=0.
- BY_ZERO: next edge -> DONE with result_o=0, ready_o=1. Latency from start sample to ready_o high is 2 edges.
- BUSY:
  - Each edge: shift the partial remainder left 1 bit, bringing in the next dividend bit (MSB first). Trial-subtract the divisor with a (WIDTH+1)-bit subtract.
  - If the difference is non-negative, keep it and shift quotient bit 1. Otherwise restore and shift quotient bit 0. Counter increments.
  - After WIDTH iterations: apply signs, register result_o, set ready_o=1, go to DONE.
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Latency: start sampled at edge E0, iterations at E1..E32, DONE entered at E33 (WIDTH=32).
- BUSY, annul_i=1 or start_i=0 at any edge: -> IDLE. ready_o and result_o stay 0; the partial result is discarded.
- DONE:
  - ready_o=1 and result_o are held while start_i=1.
  - The first edge with start_i=0 -> IDLE, ready_o<=0, result_o<=0.
  - With the normal initiator, ready_o is high for exactly 1 cycle.
- Simultaneous: rst beats all inputs. annul_i beats start_i in IDLE and BUSY. annul_i is ignored in DONE.
- Arithmetic:
  - Quotient and remainder wrap to WIDTH bits.
  - Signed MIN/-1 gives quotient 0x80000000, remainder 0.
  - |MIN| is treated as the unsigned value 0x80000000.
- Inputs are sampled only in IDLE. Operand changes during BUSY or DONE have no effect.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in IDLE, with divisor nonzero, |dividend| < |divisor| and annul_i=0, go directly to DONE on the start edge with quotient 0 and remainder = raw opdata1_i. ready_o then rises 1 edge after the start sample.
- Undefined: this case takes the full WIDTH+1-edge path and yields the same result.

Test Plan:
1. Unsigned 100/7, start held until ready -> ready_o high after E33, result_o={32'd2, 32'd14}. ready_o low the cycle after start_i drops.
2. Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat unsigned -> quotient 0x7FFFFFFC, remainder 1.
3. Divide by zero, 5/0 signed -> ready_o high 2 edges after start, result_o=0.
4. 1000/3 with annul_i pulsed at iteration 10 -> IDLE next edge, ready_o never rises. A following 9/3 -> result_o={0, 3} at E33.
5. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Start held 3 extra cycles after ready -> result held, ready_o stays 1.
6. rst asserted mid-BUSY (iteration 20) -> next edge IDLE, ready_o=0, result_o=0. With DIV_EARLY_OUT_EN, 3/7 -> ready after 1 edge, {3, 0}.
